// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and the 7-segment decoder for the display scan controller.
// Segment order is seg[6] = a ... seg[0] = g, active-low; codes A-F decode to all-off.
package display_scan_ctrl_pkg;

  localparam logic       ST_BLANK   = 1'b0;
  localparam logic       ST_DRIVE   = 1'b1;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h01;
      4'h1:    s = 7'h4F;
      4'h2:    s = 7'h12;
      4'h3:    s = 7'h06;
      4'h4:    s = 7'h4C;
      4'h5:    s = 7'h24;
      4'h6:    s = 7'h20;
      4'h7:    s = 7'h0F;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h04;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Down-counter with synchronous load; tc is high while the count sits at zero.
// The count holds at zero rather than wrapping if load is not asserted.
module scan_timer #(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= RESET_VAL;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode scan controller: BLANK/DRIVE phases per digit, frame-aligned
// value updates over valid/ready, leading-zero blanking, per-digit blink and decimal points.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GAP_CYCLES   = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic [3:0]  blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int MAXP = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXP);
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] DRIVE_LOAD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic          state;
  logic [1:0]    idx;
  logic          phase_done;
  logic          boundary;
  logic [15:0]   shadow_digits;
  logic [3:0]    shadow_dp;
  logic          pending;
  logic [15:0]   display_reg;
  logic [3:0]    dp_reg;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    cur_nib;
  logic          lz_zero;
  logic          blank_digit;
  logic [3:0]    nib;

  // Timer reloads for the opposite phase on the cycle it expires.
  scan_timer #(
    .WIDTH     (CW),
    .RESET_VAL (GAP_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (phase_done),
    .load_val ((state == ST_BLANK) ? DRIVE_LOAD : GAP_LOAD),
    .tc       (phase_done)
  );

  assign boundary   = (state == ST_DRIVE) && (idx == 2'd3) && phase_done;
  assign frame_tick = boundary;
  assign load_ready = ~pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      idx   <= 2'd0;
    end else if (phase_done) begin
      if (state == ST_BLANK) begin
        state <= ST_DRIVE;
      end else begin
        state <= ST_BLANK;
        idx   <= idx + 2'd1;
      end
    end
  end

  // pending blocks new transfers, so apply and accept never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= 16'h0000;
      shadow_dp     <= 4'h0;
      pending       <= 1'b0;
      display_reg   <= 16'hFFFF;
      dp_reg        <= 4'h0;
    end else if (boundary && pending) begin
      display_reg <= shadow_digits;
      dp_reg      <= shadow_dp;
      pending     <= 1'b0;
    end else if (load_valid && !pending) begin
      shadow_digits <= digits_in;
      shadow_dp     <= dp_in;
      pending       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Digit 0 is never leading-zero blanked, so a value of zero still shows "0".
  always_comb begin
    cur_nib = display_reg[idx*4 +: 4];
    lz_zero = 1'b0;
    case (idx)
      2'd1:    lz_zero = (display_reg[15:4] == 12'h000);
      2'd2:    lz_zero = (display_reg[15:8] == 8'h00);
      2'd3:    lz_zero = (display_reg[15:12] == 4'h0);
      default: lz_zero = 1'b0;
    endcase
    blank_digit = (blank_lz && lz_zero) || (blink_en[idx] && blink_phase);
    nib         = blank_digit ? BLANK_CODE : cur_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (state == ST_BLANK) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_decode(nib);
      dp  <= blank_digit ? 1'b1 : ~dp_reg[idx];
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=4, GAP_CYCLES=2, BLINK_FRAMES=2 (24-cycle frame).
// cyc counts clock cycles since the last reset release; outputs are sampled 1 time unit after each rising edge.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  display_scan_ctrl #(
    .REFRESH_DIV  (4),
    .GAP_CYCLES   (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the next cycle whose position within the frame is pos (always at least one step).
  task automatic goto(input int pos);
    do step(); while ((cyc % 24) != pos);
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] d);
    digits_in  = v;
    dp_in      = d;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] an_tab [24];
    an_tab = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD,
               4'hD, 4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_values an=%h seg=%h dp=%b rdy=%b tick=%b want F 7F 1 1 0", an, seg, dp, load_ready, frame_tick);
    end
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 24; k++) begin
      compared++;
      if (an !== an_tab[k] || seg !== 7'h7F || frame_tick !== (k == 23)) begin
        mismatched++;
        $display("[TB] FAIL scan_pattern cyc=%0d an=%h seg=%h tick=%b want an=%h seg=7F tick=%b", k, an, seg, frame_tick, an_tab[k], k == 23);
      end
      step();
    end
  endtask

  task automatic test_load();
    goto(5);
    compared++;
    if (load_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL load_ready_idle got %b want 1", load_ready); end
    load_value(16'h1234, 4'b0100);
    compared++;
    if (load_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL load_ready_drop got %b want 0", load_ready); end
    goto(22);
    compared++;
    if (seg !== 7'h7F || an !== 4'h7) begin mismatched++; $display("[TB] FAIL no_tearing seg=%h an=%h want 7F 7", seg, an); end
    goto(23);
    compared++;
    if (load_ready !== 1'b0 || frame_tick !== 1'b1) begin mismatched++; $display("[TB] FAIL boundary_pending rdy=%b tick=%b want 0 1", load_ready, frame_tick); end
    step();
    compared++;
    if (load_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL load_ready_return got %b want 1", load_ready); end
    goto(4);
    compared++;
    if (an !== 4'hE || seg !== 7'h4C || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL digit0_4 an=%h seg=%h dp=%b want E 4C 1", an, seg, dp); end
    goto(10);
    compared++;
    if (an !== 4'hD || seg !== 7'h06 || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL digit1_3 an=%h seg=%h dp=%b want D 06 1", an, seg, dp); end
    goto(16);
    compared++;
    if (an !== 4'hB || seg !== 7'h12 || dp !== 1'b0) begin mismatched++; $display("[TB] FAIL digit2_2dp an=%h seg=%h dp=%b want B 12 0", an, seg, dp); end
    goto(22);
    compared++;
    if (an !== 4'h7 || seg !== 7'h4F || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL digit3_1 an=%h seg=%h dp=%b want 7 4F 1", an, seg, dp); end
  endtask

  task automatic test_leading_zero();
    goto(5);
    blank_lz = 1'b1;
    load_value(16'h0070, 4'b0000);
    goto(23);
    step();
    goto(4);
    compared++;
    if (seg !== 7'h01) begin mismatched++; $display("[TB] FAIL lz_digit0 seg=%h want 01", seg); end
    goto(10);
    compared++;
    if (seg !== 7'h0F) begin mismatched++; $display("[TB] FAIL lz_digit1 seg=%h want 0F", seg); end
    goto(16);
    compared++;
    if (seg !== 7'h7F || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL lz_digit2 seg=%h dp=%b want 7F 1", seg, dp); end
    goto(22);
    compared++;
    if (seg !== 7'h7F) begin mismatched++; $display("[TB] FAIL lz_digit3 seg=%h want 7F", seg); end
    blank_lz = 1'b0;
    goto(16);
    compared++;
    if (seg !== 7'h01) begin mismatched++; $display("[TB] FAIL nolz_digit2 seg=%h want 01", seg); end
    goto(22);
    compared++;
    if (seg !== 7'h01) begin mismatched++; $display("[TB] FAIL nolz_digit3 seg=%h want 01", seg); end
  endtask

  task automatic test_blink();
    int f;
    logic [6:0] exp_seg;
    logic       exp_dp;
    goto(5);
    load_value(16'h5678, 4'b0001);
    goto(23);
    step();
    blink_en = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      goto(4);
      f = cyc / 24;
      exp_seg = (((f / 2) % 2) == 1) ? 7'h7F : 7'h00;
      exp_dp  = (((f / 2) % 2) == 1) ? 1'b1 : 1'b0;
      compared++;
      if (seg !== exp_seg || dp !== exp_dp) begin
        mismatched++;
        $display("[TB] FAIL blink_digit0 frame=%0d seg=%h dp=%b want %h %b", f, seg, dp, exp_seg, exp_dp);
      end
      goto(10);
      compared++;
      if (seg !== 7'h0F) begin mismatched++; $display("[TB] FAIL blink_digit1 frame=%0d seg=%h want 0F", f, seg); end
    end
    blink_en = 4'b0000;
  endtask

  task automatic test_back_to_back();
    goto(23);
    compared++;
    if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_boundary rdy=%b tick=%b want 1 1", load_ready, frame_tick); end
    digits_in  = 16'h0900;
    dp_in      = 4'b0000;
    load_valid = 1'b1;
    step();
    digits_in = 16'hAAAA;
    compared++;
    if (load_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ready_drop got %b want 0", load_ready); end
    goto(16);
    compared++;
    if (seg !== 7'h20) begin mismatched++; $display("[TB] FAIL b2b_deferred seg=%h want 20", seg); end
    goto(23);
    compared++;
    if (load_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ignored rdy=%b want 0", load_ready); end
    step();
    compared++;
    if (load_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready_back got %b want 1", load_ready); end
    step();
    load_valid = 1'b0;
    compared++;
    if (load_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_second_accept rdy=%b want 0", load_ready); end
    goto(16);
    compared++;
    if (seg !== 7'h04) begin mismatched++; $display("[TB] FAIL b2b_first_value seg=%h want 04", seg); end
    goto(23);
    step();
    goto(16);
    compared++;
    if (seg !== 7'h7F) begin mismatched++; $display("[TB] FAIL b2b_second_value seg=%h want 7F", seg); end
  endtask

  task automatic test_reset_midframe();
    goto(5);
    load_value(16'h1111, 4'b1111);
    goto(10);
    compared++;
    if (an !== 4'hD) begin mismatched++; $display("[TB] FAIL pre_reset_drive an=%h want D", an); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || load_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async_reset an=%h seg=%h dp=%b rdy=%b want F 7F 1 1", an, seg, dp, load_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    goto(4);
    compared++;
    if (an !== 4'hE || seg !== 7'h7F || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_digit0 an=%h seg=%h dp=%b want E 7F 1", an, seg, dp); end
    goto(23);
    compared++;
    if (frame_tick !== 1'b1 || load_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_boundary tick=%b rdy=%b want 1 1", frame_tick, load_ready); end
    step();
    goto(4);
    compared++;
    if (seg !== 7'h7F || load_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL shadow_discarded seg=%h rdy=%b want 7F 1", seg, load_ready); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_leading_zero();
    test_blink();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
